// File: rtl/led_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_seq_pkg
// Description : Mode/state encodings and mode ordering for led_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package led_seq_pkg;

    localparam logic [1:0] MODE_OFF     = 2'd0;
    localparam logic [1:0] MODE_GRAY    = 2'd1;
    localparam logic [1:0] MODE_CHASE   = 2'd2;
    localparam logic [1:0] MODE_BREATHE = 2'd3;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_BLANK = 1'b1
    } state_t;

    // Advance order: GRAY -> CHASE -> BREATHE -> OFF -> GRAY
    function automatic logic [1:0] next_mode(input logic [1:0] m);
        case (m)
            MODE_GRAY:    return MODE_CHASE;
            MODE_CHASE:   return MODE_BREATHE;
            MODE_BREATHE: return MODE_OFF;
            default:      return MODE_GRAY;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Button synchronizer, stability debounce and press-edge pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DEB_BITS = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press
);

    logic                r_sync1;
    logic                r_sync2;
    logic                r_db;
    logic                r_db_d;
    logic [DEB_BITS-1:0] r_cnt;

    // The counter only runs while the synced level disagrees with the
    // debounced level; any return to agreement restarts the stability window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_db    <= 1'b0;
            r_db_d  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
            r_db_d  <= r_db;
            if (r_sync2 == r_db) begin
                r_cnt <= '0;
            end else if (&r_cnt) begin
                r_db  <= r_sync2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign press = r_db & ~r_db_d;

endmodule
`default_nettype wire

// File: rtl/led_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : led_sequencer
// Description : LED bank mode sequencer (Gray/chase/breathe/off) with blanking.
// Revision    : 1.0 - initial release
// ============================================================================
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int NLED        = 5,
    parameter int LOG2DELAY   = 21,
    parameter int DEB_BITS    = 16,
    parameter int BLANK_TICKS = 4,
    parameter int DUTY_STEP   = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            btn,
    output logic [NLED-1:0] led,
    output logic [1:0]      mode,
    output logic            blanking,
    output logic            tick
);

    localparam logic [7:0] c_duty_step   = 8'(DUTY_STEP);
    localparam logic [3:0] c_blank_ticks = 4'(BLANK_TICKS);

    logic [LOG2DELAY-1:0] r_presc;
    logic [7:0]           w_pwm;
    logic                 w_tick;
    logic                 w_press;

    state_t               r_state;
    logic [1:0]           r_mode;
    logic [NLED-1:0]      r_led;
    logic [NLED-1:0]      r_step;
    logic [NLED-1:0]      r_chase;
    logic [7:0]           r_duty;
    logic                 r_dir_down;
    logic [3:0]           r_blank_cnt;

    logic [NLED-1:0]      w_step_nxt;
    logic [NLED-1:0]      w_chase_nxt;
    logic [7:0]           w_duty_nxt;
    logic                 w_dir_down_nxt;
    logic [8:0]           w_duty_up;
    logic [NLED-1:0]      w_pattern;
    logic [3:0]           w_blank_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    assign w_tick = &r_presc;

    generate
        if (LOG2DELAY >= 8) begin : g_pwm_slice
            assign w_pwm = r_presc[7:0];
        end else begin : g_pwm_ext
            assign w_pwm = {{(8-LOG2DELAY){1'b0}}, r_presc};
        end
    endgenerate

    btn_debounce #(
        .DEB_BITS (DEB_BITS)
    ) u_debounce (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn),
        .press   (w_press)
    );

    assign w_duty_up   = {1'b0, r_duty} + {1'b0, c_duty_step};
    assign w_blank_inc = r_blank_cnt + 4'd1;

    // Pattern state as it would be after this cycle if no press intervenes.
    always_comb begin
        w_step_nxt     = r_step;
        w_chase_nxt    = r_chase;
        w_duty_nxt     = r_duty;
        w_dir_down_nxt = r_dir_down;
        if (w_tick) begin
            case (r_mode)
                MODE_GRAY:  w_step_nxt  = r_step + 1'b1;
                MODE_CHASE: w_chase_nxt = {r_chase[NLED-2:0], r_chase[NLED-1]};
                MODE_BREATHE: begin
                    if (!r_dir_down) begin
                        if (w_duty_up > 9'd255) begin
                            w_duty_nxt     = 8'd255;
                            w_dir_down_nxt = 1'b1;
                        end else begin
                            w_duty_nxt = w_duty_up[7:0];
                        end
                    end else if (r_duty < c_duty_step) begin
                        w_duty_nxt     = 8'd0;
                        w_dir_down_nxt = 1'b0;
                    end else begin
                        w_duty_nxt = r_duty - c_duty_step;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_pattern = '0;
        case (r_mode)
            MODE_GRAY:    w_pattern = w_step_nxt ^ (w_step_nxt >> 1);
            MODE_CHASE:   w_pattern = w_chase_nxt;
            MODE_BREATHE: if (w_pwm < w_duty_nxt) w_pattern = '1;
            default:      ;
        endcase
    end

    // A press in RUN takes priority over a coincident tick; presses in BLANK are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_mode      <= MODE_GRAY;
            r_led       <= '0;
            r_step      <= '0;
            r_chase     <= {{(NLED-1){1'b0}}, 1'b1};
            r_duty      <= 8'd0;
            r_dir_down  <= 1'b0;
            r_blank_cnt <= 4'd0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_press) begin
                        r_mode      <= next_mode(r_mode);
                        r_state     <= ST_BLANK;
                        r_led       <= '0;
                        r_blank_cnt <= 4'd0;
                    end else begin
                        r_step     <= w_step_nxt;
                        r_chase    <= w_chase_nxt;
                        r_duty     <= w_duty_nxt;
                        r_dir_down <= w_dir_down_nxt;
                        r_led      <= w_pattern;
                    end
                end
                ST_BLANK: begin
                    r_led <= '0;
                    if (w_tick) begin
                        if (w_blank_inc == c_blank_ticks) begin
                            r_state     <= ST_RUN;
                            r_blank_cnt <= 4'd0;
                            r_step      <= '0;
                            r_chase     <= {{(NLED-1){1'b0}}, 1'b1};
                            r_duty      <= 8'd0;
                            r_dir_down  <= 1'b0;
                        end else begin
                            r_blank_cnt <= w_blank_inc;
                        end
                    end
                end
            endcase
        end
    end

    assign led      = r_led;
    assign mode     = r_mode;
    assign blanking = (r_state == ST_BLANK);
    assign tick     = w_tick;

endmodule
`default_nettype wire

// File: tb/tb_led_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_sequencer
// Description : Self-checking bench for led_sequencer against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_sequencer;

    localparam int NLED        = 5;
    localparam int LOG2DELAY   = 3;
    localparam int DEB_BITS    = 2;
    localparam int BLANK_TICKS = 2;
    localparam int DUTY_STEP   = 64;
    localparam int PERIOD      = 1 << LOG2DELAY;
    localparam int ALL_ON      = (1 << NLED) - 1;
    localparam int DEB_CYCLES  = 1 << DEB_BITS;

    logic            clk;
    logic            rst;
    logic            btn;
    logic [NLED-1:0] led;
    logic [1:0]      mode;
    logic            blanking;
    logic            tick;

    int n_checks = 0;
    int n_fail   = 0;

    led_sequencer #(
        .NLED        (NLED),
        .LOG2DELAY   (LOG2DELAY),
        .DEB_BITS    (DEB_BITS),
        .BLANK_TICKS (BLANK_TICKS),
        .DUTY_STEP   (DUTY_STEP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn      (btn),
        .led      (led),
        .mode     (mode),
        .blanking (blanking),
        .tick     (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reference: plain integers for every piece of observable state.
    int m_presc, m_s1, m_s2, m_db, m_db_prev, m_run;
    int m_mode, m_in_blank, m_ticks_seen;
    int m_gray, m_pos, m_duty, m_up, m_led;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_presc = 0; m_s1 = 0; m_s2 = 0; m_db = 0; m_db_prev = 0; m_run = 0;
        m_mode = 1; m_in_blank = 0; m_ticks_seen = 0;
        m_gray = 0; m_pos = 0; m_duty = 0; m_up = 1; m_led = 0;
    endfunction

    function automatic void pattern_reset();
        m_gray = 0; m_pos = 0; m_duty = 0; m_up = 1;
    endfunction

    // One clock edge of the reference, using pre-edge values of everything.
    function automatic void model_step(input int b, input int r);
        int press_now, tick_now, pwm;
        if (r != 0) begin
            model_reset();
            return;
        end
        press_now = (m_db == 1 && m_db_prev == 0) ? 1 : 0;
        tick_now  = (m_presc == PERIOD - 1) ? 1 : 0;
        pwm       = m_presc;

        m_db_prev = m_db;
        if (m_s2 != m_db) begin
            m_run++;
            if (m_run == DEB_CYCLES) begin
                m_db  = m_s2;
                m_run = 0;
            end
        end else begin
            m_run = 0;
        end
        m_s2 = m_s1;
        m_s1 = b;

        if (m_in_blank == 0) begin
            if (press_now != 0) begin
                m_mode       = (m_mode + 1) % 4;
                m_in_blank   = 1;
                m_ticks_seen = 0;
                m_led        = 0;
            end else begin
                if (tick_now != 0) begin
                    if (m_mode == 1) m_gray = (m_gray + 1) % (1 << NLED);
                    if (m_mode == 2) m_pos  = (m_pos + 1) % NLED;
                    if (m_mode == 3) begin
                        if (m_up != 0) begin
                            if (m_duty + DUTY_STEP > 255) begin m_duty = 255; m_up = 0; end
                            else m_duty = m_duty + DUTY_STEP;
                        end else begin
                            if (m_duty < DUTY_STEP) begin m_duty = 0; m_up = 1; end
                            else m_duty = m_duty - DUTY_STEP;
                        end
                    end
                end
                case (m_mode)
                    1:       m_led = m_gray ^ (m_gray >> 1);
                    2:       m_led = 1 << m_pos;
                    3:       m_led = (pwm < m_duty) ? ALL_ON : 0;
                    default: m_led = 0;
                endcase
            end
        end else begin
            m_led = 0;
            if (tick_now != 0) begin
                m_ticks_seen++;
                if (m_ticks_seen == BLANK_TICKS) begin
                    m_in_blank = 0;
                    pattern_reset();
                end
            end
        end
        m_presc = (m_presc + 1) % PERIOD;
    endfunction

    task automatic compare_outputs();
        check_val("led", 32'(led), 32'(m_led));
        check_val("mode", 32'(mode), 32'(m_mode));
        check_val("blanking", 32'(blanking), 32'(m_in_blank));
        check_val("tick", 32'(tick), (m_presc == PERIOD - 1) ? 32'd1 : 32'd0);
    endtask

    task automatic step_cycle();
        @(posedge clk);
        model_step(int'(btn), int'(rst));
        @(negedge clk);
        compare_outputs();
    endtask

    // Advance until a tick is showing, then take the edge that consumes it.
    task automatic wait_tick_then_step();
        int n = 0;
        while (tick !== 1'b1 && n < 4 * PERIOD) begin
            step_cycle();
            n++;
        end
        check_val("tick_wait", 32'(tick), 32'd1);
        step_cycle();
    endtask

    task automatic press_and_settle(input int exp_mode);
        int rises = 0;
        logic prev = blanking;
        btn = 1'b1;
        repeat (8) begin
            step_cycle();
            if (blanking && !prev) rises++;
            prev = blanking;
        end
        btn = 1'b0;
        for (int n = 0; n < 6 * PERIOD && blanking; n++) begin
            step_cycle();
            if (blanking && !prev) rises++;
            prev = blanking;
        end
        check_val("press_count", 32'(rises), 32'd1);
        check_val("settle_blank", 32'(blanking), 32'd0);
        check_val("settle_mode", 32'(mode), 32'(exp_mode));
    endtask

    task automatic async_reset_pulse();
        @(posedge clk);
        model_step(int'(btn), int'(rst));
        #2 rst = 1'b1;
        model_reset();
        #1;
        check_val("arst_led", 32'(led), 32'd0);
        check_val("arst_mode", 32'(mode), 32'd1);
        check_val("arst_blank", 32'(blanking), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        compare_outputs();
    endtask

    logic [NLED-1:0] gray_exp  [8] = '{5'b00001, 5'b00011, 5'b00010, 5'b00110,
                                       5'b00111, 5'b00101, 5'b00100, 5'b01100};
    logic [NLED-1:0] chase_exp [6] = '{5'b00010, 5'b00100, 5'b01000, 5'b10000,
                                       5'b00001, 5'b00010};
    int              duty_exp  [9] = '{64, 128, 192, 255, 191, 127, 63, 0, 64};

    initial begin
        rst = 1'b1;
        btn = 1'b0;
        model_reset();
        @(negedge clk);
        check_val("reset_led", 32'(led), 32'd0);
        check_val("reset_mode", 32'(mode), 32'd1);
        check_val("reset_blank", 32'(blanking), 32'd0);
        check_val("reset_tick", 32'(tick), 32'd0);
        repeat (2) step_cycle();
        rst = 1'b0;

        // Gray count from step 0
        for (int i = 0; i < 8; i++) begin
            wait_tick_then_step();
            check_val("gray_seq", 32'(led), 32'(gray_exp[i]));
        end

        // Short glitch must not register
        btn = 1'b1;
        repeat (3) step_cycle();
        btn = 1'b0;
        repeat (8) step_cycle();
        check_val("glitch_mode", 32'(mode), 32'd1);
        check_val("glitch_blank", 32'(blanking), 32'd0);

        press_and_settle(2);

        for (int i = 0; i < 6; i++) begin
            wait_tick_then_step();
            check_val("chase_seq", 32'(led), 32'(chase_exp[i]));
        end

        press_and_settle(3);

        for (int i = 0; i < 9; i++) begin
            int exp_led;
            wait_tick_then_step();
            exp_led = (duty_exp[i] > 0) ? ALL_ON : 0;
            check_val("breathe_led", 32'(led), 32'(exp_led));
            if (duty_exp[i] == 255 || duty_exp[i] == 0) begin
                repeat (PERIOD - 1) begin
                    step_cycle();
                    check_val("breathe_window", 32'(led), 32'(exp_led));
                end
            end
        end

        press_and_settle(0);
        press_and_settle(1);

        // Press lands on a tick edge, a second press lands inside the blank
        for (int n = 0; n < 2 * PERIOD && tick !== 1'b1; n++) step_cycle();
        repeat (2) step_cycle();
        btn = 1'b1;
        repeat (6) step_cycle();
        btn = 1'b0;
        step_cycle();
        check_val("collide_blank", 32'(blanking), 32'd1);
        check_val("collide_led", 32'(led), 32'd0);
        repeat (5) step_cycle();
        btn = 1'b1;
        repeat (6) step_cycle();
        btn = 1'b0;
        for (int n = 0; n < 6 * PERIOD && blanking; n++) step_cycle();
        check_val("dbl_press_mode", 32'(mode), 32'd2);
        check_val("dbl_press_blank", 32'(blanking), 32'd0);

        // Asynchronous reset in the middle of a blank
        btn = 1'b1;
        repeat (8) step_cycle();
        btn = 1'b0;
        step_cycle();
        check_val("pre_arst_blank", 32'(blanking), 32'd1);
        async_reset_pulse();
        wait_tick_then_step();
        check_val("post_arst_gray0", 32'(led), 32'd1);
        wait_tick_then_step();
        check_val("post_arst_gray1", 32'(led), 32'd3);

        // Randomized button activity with occasional resets
        for (int seg = 0; seg < 250; seg++) begin
            btn = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 12)) step_cycle();
            if ($urandom_range(0, 49) == 0) async_reset_pulse();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/led_sequencer.md
Name: led_sequencer

Overview:
Controller that sequences the LED bank of the icestick top-level through display modes: Gray-code count, one-hot chase, PWM breathe and off. A debounced push-button advances the mode. Each mode change passes through a timed blanking interval. It replaces the free-running counter/LED wiring in top; its led bus drives the board LED pins directly.

Parameters:
NLED, 5, number of LED outputs (2..8)
LOG2DELAY, 21, tick period = 2^LOG2DELAY clk cycles
DEB_BITS, 16, button must be stable 2^DEB_BITS cycles to register
BLANK_TICKS, 4, ticks LEDs stay dark between modes (1..15)
DUTY_STEP, 8, breathe duty increment per tick (1..128)

Ports:
clk  in  1  system clock, single domain
rst  in  1  asynchronous, active-high reset
btn  in  1  raw push-button, asynchronous to clk, active-high
led  out  NLED  LED drive, registered
mode  out  2  current mode: 0 OFF, 1 GRAY, 2 CHASE, 3 BREATHE
blanking  out  1  high while in the BLANK state
tick  out  1  one-cycle pulse at each prescaler wrap (debug/test)

Behaviour:
- Single clock `clk`. Reset `rst` is asynchronous and active-high. All flops clear on rst assertion.
- Reset values: led=0, mode=1 (GRAY), blanking=0, tick=0, prescaler=0, step=0, chase=1, duty=0, dir=up, btn sync/debounce=0.
- Prescaler: LOG2DELAY-bit up-counter that wraps. tick=1 on the cycle the counter equals all-ones.
- Button path: 2-flop synchronizer feeds a DEB_BITS counter.
  - Counter clears whenever the synced value equals btn_db.
  - On counter saturation, btn_db takes the synced value.
  - press = one-cycle pulse on the btn_db 0->1 edge. Release makes no pulse.
- FSM states: RUN, BLANK. Next-mode order: GRAY->CHASE->BREATHE->OFF->GRAY.
  - RUN + press: latch next mode into mode and go to BLANK on the following cycle. led=0 and blank_cnt=0 from that cycle.
  - BLANK: led=0, blanking=1. blank_cnt increments on tick.
  - BLANK exit: when blank_cnt reaches BLANK_TICKS on a tick, return to RUN. Clear step/chase/duty/dir to reset values.
  - press while in BLANK is ignored (dropped, not queued).
  - press coincident with tick in RUN: press wins; the tick's pattern update is discarded.
- RUN pattern updates (led registered, changes the cycle after tick):
  - GRAY: step (NLED bits) increments on tick, wrapping. led = step ^ (step>>1).
  - CHASE: one-hot chase register rotates left on tick; bit NLED-1 wraps to bit 0. led = chase.
  - BREATHE:
    - duty is 8-bit, updated on tick: +DUTY_STEP while up, -DUTY_STEP while down.
    - Going up, if duty+DUTY_STEP > 255: clamp to 255 and set dir=down.
    - Going down, if duty < DUTY_STEP: clamp to 0 and set dir=up.
    - pwm = prescaler[7:0] (for LOG2DELAY<8, prescaler zero-extended).
    - led = all ones when pwm < duty, else 0. duty=0 gives always off.
  - OFF: led=0. Prescaler keeps running.
- No pattern state advances during BLANK.
- Prescaler runs in all states and is never cleared except by rst.
- btn glitches shorter than 2^DEB_BITS cycles have no effect.
- rst mid-blank or mid-pattern returns to GRAY/RUN immediately; no pending press survives.

Decomposition:
- Package led_seq_pkg holds:
  - mode encodings MODE_OFF/GRAY/CHASE/BREATHE (2-bit localparams)
  - FSM state encodings ST_RUN/ST_BLANK
  - next_mode function
- Sub-module btn_debounce (clk, rst, btn_raw, press; param DEB_BITS) contains the synchronizer, debounce counter and edge detect.
- Prescaler, FSM and pattern generators stay in led_sequencer.

Test Plan:
(All scenarios use LOG2DELAY=3, DEB_BITS=2, BLANK_TICKS=2, NLED=5, DUTY_STEP=64.)
- Reset/GRAY: release rst, run 8 ticks -> led sequence 00001,00011,00010,00110,00111,00101,00100,01100. Each change lands 1 cycle after a tick pulse.
- Debounce: btn high for 3 cycles -> no press, mode stays 1. btn high for 8 cycles -> exactly one press; blanking=1, led=0; after 2 ticks mode=2, blanking=0.
- CHASE wrap: in CHASE, 6 ticks -> led 00010,00100,01000,10000,00001,00010.
- BREATHE clamp: in BREATHE, ticks give duty 64,128,192,255,191,127,63,0,64. Over one full 8-cycle pwm window at duty=255 -> led high for all 8 cycles; at duty 0 -> never high.
- Press in BLANK / press+tick collision: second press mid-blank -> ignored, ends in CHASE not BREATHE. Press on a tick cycle in GRAY -> step unchanged, enters BLANK.
- Async reset mid-BLANK: assert rst asynchronously between clk edges -> led=0, mode=1, blanking=0 immediately. After release, GRAY resumes from step 0.
